// File: rtl/frog_pkg.sv
// Shared encodings and default geometry for the frog game controller.
// Direction codes double as the move-queue payload.
package frog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_BACK  = 2'd1,
        DIR_FWD   = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int unsigned DEF_GRID_SIZE = 32;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_START_X   = 320;
    localparam int unsigned DEF_START_Y   = 448;

    // Request bits are [0] left, [1] back, [2] forward, [3] right; forward wins, right loses.
    function automatic dir_t pick_dir(input logic [3:0] req);
        if (req[2]) begin
            return DIR_FWD;
        end else if (req[1]) begin
            return DIR_BACK;
        end else if (req[0]) begin
            return DIR_LEFT;
        end else begin
            return DIR_RIGHT;
        end
    endfunction

endpackage

// File: rtl/frog_game_controller_if.sv
// Game-side signal bundle between the switch/frame logic and the frog controller.
interface frog_game_controller_if;
    logic [3:0] i_Move_Req;
    logic       i_Frame_Tick;
    logic       i_Collision;
    logic       i_Start;
    logic [9:0] o_Frog_X;
    logic [9:0] o_Frog_Y;
    logic [3:0] o_Level;
    logic [1:0] o_Lives;
    logic [1:0] o_State;
    logic       o_Fifo_Full;

    modport master (
        output i_Move_Req, i_Frame_Tick, i_Collision, i_Start,
        input  o_Frog_X, o_Frog_Y, o_Level, o_Lives, o_State, o_Fifo_Full
    );

    modport slave (
        input  i_Move_Req, i_Frame_Tick, i_Collision, i_Start,
        output o_Frog_X, o_Frog_Y, o_Level, o_Lives, o_State, o_Fifo_Full
    );
endinterface

// File: rtl/frog_game_controller_move_fifo.sv
// Small synchronous queue of pending move directions.
// A push into a full queue is accepted only when a pop happens on the same edge.
module move_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; flush discards everything queued.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end
endmodule

// File: rtl/frog_game_controller.sv
// Frog sequencer: queues direction requests, applies one grid step per frame,
// and tracks level, lives and the death/respawn cycle.
module frog_game_controller
    import frog_pkg::*;
#(
    parameter int unsigned GRID_SIZE      = DEF_GRID_SIZE,
    parameter int unsigned H_DISPLAY      = DEF_H_DISPLAY,
    parameter int unsigned V_DISPLAY      = DEF_V_DISPLAY,
    parameter int unsigned START_X        = DEF_START_X,
    parameter int unsigned START_Y        = DEF_START_Y,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    frog_game_controller_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(RESPAWN_FRAMES + 1);

    localparam logic [9:0]       GRID_C     = 10'(GRID_SIZE);
    localparam logic [9:0]       X_MAX_C    = 10'(H_DISPLAY - 2 * GRID_SIZE);
    localparam logic [9:0]       Y_MAX_C    = 10'(V_DISPLAY - 2 * GRID_SIZE);
    localparam logic [9:0]       START_X_C  = 10'(START_X);
    localparam logic [9:0]       START_Y_C  = 10'(START_Y);
    localparam logic [1:0]       LIVES_C    = 2'(LIVES);
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(RESPAWN_FRAMES - 1);

    state_t           state_r;
    logic [9:0]       x_r;
    logic [9:0]       y_r;
    logic [3:0]       level_r;
    logic [1:0]       lives_r;
    logic [CNT_W-1:0] resp_cnt_r;

    logic       in_play_s;
    logic       start_s;
    logic       die_s;
    logic       pop_s;
    logic       push_s;
    logic       flush_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [1:0] head_s;
    dir_t       head_dir_s;
    logic [9:0] move_x_s;
    logic [9:0] move_y_s;
    logic [3:0] move_lvl_s;

    assign in_play_s  = (state_r == ST_PLAY);
    assign start_s    = bus.i_Start && ((state_r == ST_IDLE) || (state_r == ST_GAME_OVER));
    assign die_s      = in_play_s && bus.i_Frame_Tick && bus.i_Collision;
    assign pop_s      = in_play_s && bus.i_Frame_Tick && !bus.i_Collision && !fifo_empty_s;
    assign push_s     = in_play_s && (bus.i_Move_Req != 4'd0);
    assign flush_s    = die_s || start_s;
    assign head_dir_s = dir_t'(head_s);

    move_fifo #(
        .DEPTH (4),
        .WIDTH (2)
    ) u_move_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (flush_s),
        .wr_data (pick_dir(bus.i_Move_Req)),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Candidate position for the queued move at the head; bounds checked before the arithmetic.
    always_comb begin
        move_x_s   = x_r;
        move_y_s   = y_r;
        move_lvl_s = level_r;
        case (head_dir_s)
            DIR_LEFT: begin
                if (x_r >= GRID_C) move_x_s = x_r - GRID_C;
                else               move_x_s = x_r;
            end
            DIR_RIGHT: begin
                if (x_r <= X_MAX_C) move_x_s = x_r + GRID_C;
                else                move_x_s = x_r;
            end
            DIR_BACK: begin
                if (y_r <= Y_MAX_C) move_y_s = y_r + GRID_C;
                else                move_y_s = y_r;
            end
            DIR_FWD: begin
                if (y_r >= GRID_C) begin
                    move_y_s = y_r - GRID_C;
                end else begin
                    // Reaching the top row completes the level and sends the frog home.
                    move_x_s = START_X_C;
                    move_y_s = START_Y_C;
                    if (level_r != 4'd15) move_lvl_s = level_r + 4'd1;
                    else                  move_lvl_s = level_r;
                end
            end
            default: begin
                move_x_s = x_r;
            end
        endcase
    end

    // Game FSM with position, level, lives and respawn counter all held in registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r    <= ST_IDLE;
            x_r        <= START_X_C;
            y_r        <= START_Y_C;
            level_r    <= 4'd1;
            lives_r    <= LIVES_C;
            resp_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start_s) begin
                        state_r    <= ST_PLAY;
                        x_r        <= START_X_C;
                        y_r        <= START_Y_C;
                        level_r    <= 4'd1;
                        lives_r    <= LIVES_C;
                        resp_cnt_r <= '0;
                    end
                end
                ST_PLAY: begin
                    if (die_s) begin
                        state_r    <= ST_DYING;
                        resp_cnt_r <= '0;
                        if (lives_r != 2'd0) lives_r <= lives_r - 2'd1;
                    end else if (pop_s) begin
                        x_r     <= move_x_s;
                        y_r     <= move_y_s;
                        level_r <= move_lvl_s;
                    end
                end
                ST_DYING: begin
                    if (bus.i_Frame_Tick) begin
                        if (resp_cnt_r == CNT_LAST_C) begin
                            resp_cnt_r <= '0;
                            if (lives_r == 2'd0) begin
                                state_r <= ST_GAME_OVER;
                            end else begin
                                state_r <= ST_PLAY;
                                x_r     <= START_X_C;
                                y_r     <= START_Y_C;
                            end
                        end else begin
                            resp_cnt_r <= resp_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Frog_X    = x_r;
    assign bus.o_Frog_Y    = y_r;
    assign bus.o_Level     = level_r;
    assign bus.o_Lives     = lives_r;
    assign bus.o_State     = state_r;
    assign bus.o_Fifo_Full = fifo_full_s;
endmodule

// File: tb/tb_frog_game_controller.sv
// Self-checking bench for frog_game_controller: directed game scenarios followed by
// random play, every cycle compared against a queue-based model of the game rules.
module tb_frog_game_controller;
    logic i_Clk;
    logic i_Rst_L;
    int   n_cmp;
    int   n_mis;

    frog_game_controller_if bus ();

    frog_game_controller dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Reference model: plain integers and a queue of direction codes (0 L, 1 B, 2 F, 3 R).
    int m_state;
    int m_x;
    int m_y;
    int m_lvl;
    int m_lives;
    int m_cnt;
    int mq[$];

    task automatic model_reset();
        m_state = 0; m_x = 320; m_y = 448; m_lvl = 1; m_lives = 3; m_cnt = 0;
        mq.delete();
    endtask

    function automatic int dir_of(input int req);
        if ((req & 4) != 0) return 2;
        if ((req & 2) != 0) return 1;
        if ((req & 1) != 0) return 0;
        return 3;
    endfunction

    task automatic model_apply(input int code);
        case (code)
            0: if (m_x >= 32) m_x -= 32;
            3: if (m_x + 32 + 32 <= 640) m_x += 32;
            1: if (m_y + 32 + 32 <= 480) m_y += 32;
            default: begin
                if (m_y >= 32) m_y -= 32;
                else begin
                    m_x = 320; m_y = 448;
                    m_lvl = (m_lvl < 15) ? m_lvl + 1 : 15;
                end
            end
        endcase
    endtask

    task automatic model_step(input int req, input bit tick, input bit col, input bit start);
        case (m_state)
            1: begin
                if (tick && col) begin
                    m_state = 2; m_cnt = 0; mq.delete();
                    if (m_lives > 0) m_lives--;
                end else begin
                    if (tick && mq.size() > 0) model_apply(mq.pop_front());
                    if (req != 0 && mq.size() < 4) mq.push_back(dir_of(req));
                end
            end
            2: begin
                if (tick) begin
                    m_cnt++;
                    if (m_cnt == 60) begin
                        m_cnt = 0;
                        if (m_lives == 0) m_state = 3;
                        else begin m_state = 1; m_x = 320; m_y = 448; end
                    end
                end
            end
            default: begin
                if (start) begin
                    m_state = 1; m_x = 320; m_y = 448; m_lvl = 1; m_lives = 3;
                    mq.delete();
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},     32'(bus.o_Frog_X),    32'(m_x));
        chk({tag, ".y"},     32'(bus.o_Frog_Y),    32'(m_y));
        chk({tag, ".level"}, 32'(bus.o_Level),     32'(m_lvl));
        chk({tag, ".lives"}, 32'(bus.o_Lives),     32'(m_lives));
        chk({tag, ".state"}, 32'(bus.o_State),     32'(m_state));
        chk({tag, ".full"},  32'(bus.o_Fifo_Full), (mq.size() == 4) ? 32'd1 : 32'd0);
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, compare 1 ns later.
    task automatic cyc(input int req, input bit tick, input bit col, input bit start);
        @(negedge i_Clk);
        bus.i_Move_Req   = 4'(req);
        bus.i_Frame_Tick = tick;
        bus.i_Collision  = col;
        bus.i_Start      = start;
        @(posedge i_Clk);
        model_step(req, tick, col, start);
        #1;
        bus.i_Move_Req   = 4'd0;
        bus.i_Frame_Tick = 1'b0;
        bus.i_Collision  = 1'b0;
        bus.i_Start      = 1'b0;
        check_all("cyc");
    endtask

    task automatic move_and_tick(input int req, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(req, 1'b0, 1'b0, 1'b0);
            cyc(0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        model_reset();
        #1;
        check_all("reset");
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        i_Rst_L          = 1'b0;
        bus.i_Move_Req   = 4'd0;
        bus.i_Frame_Tick = 1'b0;
        bus.i_Collision  = 1'b0;
        bus.i_Start      = 1'b0;
        model_reset();
        do_reset();
        chk("reset_state", 32'(bus.o_State), 32'd0);
        chk("reset_x",     32'(bus.o_Frog_X), 32'd320);
        chk("reset_lives", 32'(bus.o_Lives), 32'd3);

        // Requests in IDLE are ignored, then start the game.
        cyc(8, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0, 1'b1);
        ticks(3);
        chk("start_state", 32'(bus.o_State), 32'd1);
        chk("start_y",     32'(bus.o_Frog_Y), 32'd448);

        move_and_tick(8, 1);
        chk("right_x", 32'(bus.o_Frog_X), 32'd352);
        move_and_tick(1, 12);
        chk("left_edge_x", 32'(bus.o_Frog_X), 32'd0);
        move_and_tick(1, 2);
        chk("left_clamp_x", 32'(bus.o_Frog_X), 32'd0);
        move_and_tick(2, 1);
        chk("back_clamp_y", 32'(bus.o_Frog_Y), 32'd448);
        move_and_tick(4, 14);
        chk("top_row_y", 32'(bus.o_Frog_Y), 32'd0);
        move_and_tick(4, 1);
        chk("level_up_y",  32'(bus.o_Frog_Y), 32'd448);
        chk("level_up_lv", 32'(bus.o_Level), 32'd2);

        // Priority and same-cycle request+tick on an empty queue.
        cyc(15, 1'b1, 1'b0, 1'b0);
        chk("same_cycle_y", 32'(bus.o_Frog_Y), 32'd448);
        ticks(1);
        chk("prio_fwd_y", 32'(bus.o_Frog_Y), 32'd416);

        // Fill the queue, drop the fifth, then push+pop while full.
        for (int i = 0; i < 4; i++) cyc(2, 1'b0, 1'b0, 1'b0);
        chk("full_after_4", 32'(bus.o_Fifo_Full), 32'd1);
        cyc(8, 1'b0, 1'b0, 1'b0);
        cyc(2, 1'b1, 1'b0, 1'b0);
        chk("full_push_pop", 32'(bus.o_Fifo_Full), 32'd1);

        // Collision with a non-empty queue, then the respawn wait.
        cyc(0, 1'b1, 1'b1, 1'b0);
        chk("die_state", 32'(bus.o_State), 32'd2);
        chk("die_lives", 32'(bus.o_Lives), 32'd2);
        chk("die_full",  32'(bus.o_Fifo_Full), 32'd0);
        cyc(4, 1'b1, 1'b0, 1'b1);
        ticks(58);
        chk("dying_59", 32'(bus.o_State), 32'd2);
        ticks(1);
        chk("respawn_state", 32'(bus.o_State), 32'd1);
        chk("respawn_level", 32'(bus.o_Level), 32'd2);

        for (int k = 0; k < 2; k++) begin
            cyc(0, 1'b1, 1'b1, 1'b0);
            ticks(60);
        end
        chk("game_over", 32'(bus.o_State), 32'd3);
        chk("game_over_lives", 32'(bus.o_Lives), 32'd0);
        move_and_tick(4, 2);
        cyc(0, 1'b0, 1'b0, 1'b1);
        chk("restart_lives", 32'(bus.o_Lives), 32'd3);
        chk("restart_level", 32'(bus.o_Level), 32'd1);

        // Random play against the model.
        for (int i = 0; i < 1500; i++) begin
            int  req;
            bit  tick;
            bit  col;
            req  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
            tick = ($urandom_range(0, 2) == 0);
            col  = tick && ($urandom_range(0, 24) == 0);
            cyc(req, tick, col, ($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset in the middle of DYING.
        do_reset();
        cyc(0, 1'b0, 1'b0, 1'b1);
        move_and_tick(8, 2);
        cyc(4, 1'b1, 1'b1, 1'b0);
        ticks(5);
        @(negedge i_Clk);
        #2;
        i_Rst_L = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        chk("mid_reset_state", 32'(bus.o_State), 32'd0);
        chk("mid_reset_x",     32'(bus.o_Frog_X), 32'd320);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        cyc(0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
